// File: rtl/pdp1_pkg.sv
// rtl/pdp1_pkg.sv - shared constants, state type and helpers for the PDP-1 core
package pdp1_pkg;

  localparam int CLK_NS         = 20;
  localparam int TP_SPACING_DEF = 25;
  localparam int NUM_TP_DEF     = 10;
  localparam int IOH_TP_DEF     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    IOWAIT = 2'd2
  } tp_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tp_tick.sv
// rtl/tp_tick.sv - reloadable down-counter timing the gap between TP pulses
module tp_tick #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pdp1_tp_seq.sv
// rtl/pdp1_tp_seq.sv - PDP-1 memory-cycle timing-pulse sequencer (TP0..TP9)
module pdp1_tp_seq
  import pdp1_pkg::*;
#(
  parameter int TP_SPACING = TP_SPACING_DEF,
  parameter int NUM_TP     = NUM_TP_DEF,
  parameter int IOH_TP     = IOH_TP_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_single,
  input  logic              i_ioh,
  input  logic              i_io_done,
  output logic [NUM_TP-1:0] o_tp,
  output logic [3:0]        o_tp_idx,
  output logic              o_running,
  output logic              o_io_wait,
  output logic              o_cyc_end
);

  localparam int              CNT_W    = cnt_width(TP_SPACING);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(TP_SPACING - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_TP - 1);

  tp_state_e         r_state;
  tp_state_e         w_next;
  logic [3:0]        r_idx;
  logic              r_stop_pend;
  logic [NUM_TP-1:0] r_tp;
  logic [3:0]        r_tp_idx;
  logic              r_running;
  logic              r_io_wait;
  logic              r_cyc_end;
  logic              w_zero;
  logic              w_fire;
  logic              w_load;
  logic              w_en;
  logic              w_halt;
  logic [CNT_W-1:0]  w_load_val;
  logic [NUM_TP-1:0] w_tp_next;

  tp_tick #(.W(CNT_W)) u_tick (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  assign w_tp_next = NUM_TP'(1) << r_idx;

  // Stop/IO decisions are taken on the clock where the TP pulse is visible.
  always_comb begin
    w_next     = r_state;
    w_fire     = 1'b0;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_halt     = 1'b0;
    w_load_val = RELOAD;
    case (r_state)
      IDLE: begin
        w_load = 1'b1;
        if (i_start) begin
          w_fire = 1'b1;
          w_next = RUN;
        end else begin
          w_load_val = '0;
        end
      end
      RUN: begin
        if (w_zero) begin
          w_fire = 1'b1;
          w_load = 1'b1;
        end else begin
          w_en = 1'b1;
        end
        if (r_tp[NUM_TP-1] && (r_stop_pend || i_single)) begin
          w_halt = 1'b1;
          w_next = IDLE;
        end else if (r_tp[IOH_TP] && i_ioh && !i_io_done) begin
          w_next = IOWAIT;
          w_load = 1'b1;
          w_en   = 1'b0;
        end
      end
      IOWAIT: begin
        // Counter holds the full spacing; io_done resumes it like a fresh pulse.
        w_en = i_io_done;
        if (i_io_done) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_stop_pend <= 1'b0;
      r_tp        <= '0;
      r_tp_idx    <= '0;
      r_running   <= 1'b0;
      r_io_wait   <= 1'b0;
      r_cyc_end   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next != IDLE);
      r_io_wait <= (w_next == IOWAIT);
      r_tp      <= w_fire ? w_tp_next : '0;
      r_cyc_end <= w_fire && (r_idx == LAST_IDX);
      if (w_fire) begin
        r_tp_idx <= r_idx;
        r_idx    <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
      end
      if (i_stop) begin
        r_stop_pend <= 1'b1;
      end else if (w_halt || (r_state == IDLE && i_start)) begin
        r_stop_pend <= 1'b0;
      end
    end
  end

  assign o_tp      = r_tp;
  assign o_tp_idx  = r_tp_idx;
  assign o_running = r_running;
  assign o_io_wait = r_io_wait;
  assign o_cyc_end = r_cyc_end;

endmodule

// File: tb/tb_pdp1_tp_seq.sv
// tb/tb_pdp1_tp_seq.sv - directed bench for the PDP-1 timing-pulse sequencer
module tb_pdp1_tp_seq;

  logic       clk = 1'b0;
  logic       reset, start, stop, single, ioh, io_done;
  logic [9:0] tp;
  logic [3:0] tp_idx;
  logic       running, io_wait, cyc_end;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [9:0] tp;
    logic [3:0] idx;
    logic       run;
    logic       iow;
    logic       ce;
  } exp_t;

  always #10 clk = ~clk;

  pdp1_tp_seq dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_stop    (stop),
    .i_single  (single),
    .i_ioh     (ioh),
    .i_io_done (io_done),
    .o_tp      (tp),
    .o_tp_idx  (tp_idx),
    .o_running (running),
    .o_io_wait (io_wait),
    .o_cyc_end (cyc_end)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Free run with start sampled at the end of cycle 0, spacing 25, ten pulses.
  function automatic exp_t fr(input int c);
    exp_t e;
    e = '0;
    if (c >= 1) begin
      e.run = 1'b1;
      e.idx = 4'(((c - 1) / 25) % 10);
      if ((c - 1) % 25 == 0) e.tp = 10'(1) << e.idx;
      e.ce = e.tp[9];
    end
    return e;
  endfunction

  function automatic exp_t idle_after(input int c);
    exp_t e;
    e     = fr(c);
    e.tp  = '0;
    e.ce  = 1'b0;
    e.run = 1'b0;
    return e;
  endfunction

  function automatic exp_t expect_at(input int scn, input int c);
    exp_t e;
    case (scn)
      1: e = (c <= 226) ? fr(c) : idle_after(226);
      2: begin
        if (c <= 226)      e = fr(c);
        else if (c <= 300) e = idle_after(226);
        else if (c <= 526) e = fr(c - 300);
        else               e = idle_after(226);
      end
      3: begin
        if (c <= 176) begin
          e = fr(c);
        end else if (c < 525) begin
          e     = fr(176);
          e.tp  = '0;
          e.ce  = 1'b0;
          e.iow = (c <= 500);
        end else begin
          e = fr(c - 324);
        end
      end
      5: begin
        if (c <= 130)      e = fr(c);
        else if (c <= 140) e = '0;
        else               e = fr(c - 140);
      end
      default: e = fr(c);
    endcase
    return e;
  endfunction

  task automatic drive(input int scn);
    start   = (cyc == 0) || (scn == 2 && cyc == 300) || (scn == 5 && cyc == 140) ||
              (scn == 6 && cyc == 50);
    stop    = (scn == 1 && cyc == 100);
    single  = (scn == 2);
    ioh     = (scn == 3 && cyc >= 170 && cyc <= 180) || (scn == 4 && cyc == 176);
    io_done = (scn == 3 && cyc == 500) || (scn == 4 && cyc == 176) || (scn == 6 && cyc == 60);
    reset   = (scn == 5 && cyc == 130);
  endtask

  task automatic do_reset();
    start   = 1'b0;
    stop    = 1'b0;
    single  = 1'b0;
    ioh     = 1'b0;
    io_done = 1'b0;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    step();
  endtask

  task automatic run_scn(input int scn, input int last);
    exp_t e;
    do_reset();
    cyc = 0;
    while (cyc < last) begin
      drive(scn);
      step();
      e = expect_at(scn, cyc);
      check_val($sformatf("s%0d_tp", scn), 32'(tp), 32'(e.tp));
      check_val($sformatf("s%0d_idx", scn), 32'(tp_idx), 32'(e.idx));
      check_val($sformatf("s%0d_running", scn), 32'(running), 32'(e.run));
      check_val($sformatf("s%0d_io_wait", scn), 32'(io_wait), 32'(e.iow));
      check_val($sformatf("s%0d_cyc_end", scn), 32'(cyc_end), 32'(e.ce));
    end
  endtask

  initial begin
    do_reset();
    check_val("rst_tp", 32'(tp), 32'd0);
    check_val("rst_idx", 32'(tp_idx), 32'd0);
    check_val("rst_running", 32'(running), 32'd0);
    check_val("rst_io_wait", 32'(io_wait), 32'd0);
    check_val("rst_cyc_end", 32'(cyc_end), 32'd0);

    run_scn(0, 1010);
    run_scn(1, 300);
    run_scn(2, 560);
    run_scn(3, 600);
    run_scn(4, 260);
    run_scn(5, 200);
    run_scn(6, 260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
